// File: rtl/bp_mem_chan_mux_if.sv
// Bundle of upstream command/response channels and the downstream
// memory port of the memory channel mux.
interface bp_mem_chan_mux_if #(
  parameter int num_chan_p = 2,
  parameter int width_p    = 128
);
  logic [num_chan_p*width_p-1:0] cmd_i;
  logic [num_chan_p-1:0]         cmd_v_i;
  logic [num_chan_p-1:0]         cmd_ready_o;
  logic [width_p-1:0]            cmd_o;
  logic                          cmd_v_o;
  logic                          cmd_yumi_i;
  logic [width_p-1:0]            resp_i;
  logic                          resp_v_i;
  logic                          resp_ready_o;
  logic [width_p-1:0]            resp_o;
  logic [num_chan_p-1:0]         resp_v_o;
  logic [num_chan_p-1:0]         resp_yumi_i;
  logic                          err_o;

  modport slave (
    input  cmd_i, cmd_v_i, cmd_yumi_i,
    input  resp_i, resp_v_i, resp_yumi_i,
    output cmd_ready_o, cmd_o, cmd_v_o,
    output resp_ready_o, resp_o, resp_v_o,
    output err_o
  );

  modport master (
    output cmd_i, cmd_v_i, cmd_yumi_i,
    output resp_i, resp_v_i, resp_yumi_i,
    input  cmd_ready_o, cmd_o, cmd_v_o,
    input  resp_ready_o, resp_o, resp_v_o,
    input  err_o
  );
endinterface

// File: rtl/bp_mem_chan_mux.sv
// Round-robin mux of N command channels onto one memory port, with
// in-order responses routed back to the issuing channel by tag FIFO.
module bp_mem_chan_mux #(
  parameter int num_chan_p = 2,
  parameter int width_p    = 128,
  parameter int els_p      = 4
) (
  input logic              clk_i,
  input logic              reset_n_i,
  bp_mem_chan_mux_if.slave bus
);
  localparam int id_w  = $clog2(num_chan_p);
  localparam int cnt_w = $clog2(els_p + 1);
  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;

  typedef logic [id_w-1:0]  id_t;
  typedef logic [cnt_w-1:0] cnt_t;
  typedef logic [ptr_w-1:0] ptr_t;

  localparam id_t  last_id  = id_t'(num_chan_p - 1);
  localparam cnt_t max_cnt  = cnt_t'(els_p);
  localparam ptr_t last_ptr = ptr_t'(els_p - 1);

  logic                  cmd_v_r;
  logic [width_p-1:0]    cmd_r;
  logic [width_p-1:0]    resp_r;
  logic [num_chan_p-1:0] resp_v_r;
  cnt_t                  cnt_r;
  ptr_t                  wptr_r;
  ptr_t                  rptr_r;
  id_t                   last_r;
  logic                  err_r;
  id_t                   tags_r [els_p];

  logic                  cmd_fire;
  logic                  resp_full;
  logic                  resp_hit;
  logic                  resp_acc;
  logic                  resp_ready;
  logic                  room;
  logic                  found;
  logic                  grant;
  logic                  bad;
  cnt_t                  unans;
  id_t                   scan;
  id_t                   win;
  logic [num_chan_p-1:0] ready;
  logic [num_chan_p-1:0] head_oh;

  // Credit and handshake qualifiers derived from current state.
  always_comb begin
    cmd_fire   = cmd_v_r & bus.cmd_yumi_i;
    resp_full  = |resp_v_r;
    resp_hit   = |(bus.resp_yumi_i & resp_v_r);
    unans      = cnt_r - cnt_t'(cmd_v_r)
               - cnt_t'(resp_full);
    room       = reset_n_i
               & (~cmd_v_r | cmd_fire)
               & (cnt_r < max_cnt);
    resp_ready = reset_n_i & ~resp_full
               & (unans != '0);
    resp_acc   = bus.resp_v_i & resp_ready;
    bad        = (bus.resp_v_i & (unans == '0))
               | (|(bus.resp_yumi_i & ~resp_v_r))
               | (bus.cmd_yumi_i & ~cmd_v_r);
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found = 1'b0;
    win   = last_r;
    scan  = last_r;
    for (int k = 0; k < num_chan_p; k++) begin
      scan = (scan == last_id) ? '0 : scan + 1'b1;
      if (!found && bus.cmd_v_i[scan]) begin
        found = 1'b1;
        win   = scan;
      end
    end
    grant = found & room;
    ready = '0;
    if (grant) ready[win] = 1'b1;
  end

  // One-hot of the channel owning the oldest unanswered command.
  always_comb begin
    head_oh = '0;
    head_oh[tags_r[rptr_r]] = 1'b1;
  end

  // Control state: valids, credit count, tag pointers, arbiter, error.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cmd_v_r  <= 1'b0;
      resp_v_r <= '0;
      cnt_r    <= '0;
      wptr_r   <= '0;
      rptr_r   <= '0;
      last_r   <= last_id;
      err_r    <= 1'b0;
    end else begin
      if (grant) begin
        cmd_v_r <= 1'b1;
        last_r  <= win;
        wptr_r  <= (wptr_r == last_ptr) ? '0 : wptr_r + 1'b1;
      end else if (cmd_fire) begin
        cmd_v_r <= 1'b0;
      end
      if (resp_acc) begin
        resp_v_r <= head_oh;
      end else if (resp_hit) begin
        resp_v_r <= '0;
        rptr_r   <= (rptr_r == last_ptr) ? '0 : rptr_r + 1'b1;
      end
      unique case ({grant, resp_hit})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
      err_r <= err_r | bad;
    end
  end

  // Payload registers and tag storage carry no reset.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      cmd_r          <= bus.cmd_i[win*width_p +: width_p];
      tags_r[wptr_r] <= win;
    end
    if (resp_acc) resp_r <= bus.resp_i;
  end

  assign bus.cmd_ready_o  = ready;
  assign bus.cmd_o        = cmd_r;
  assign bus.cmd_v_o      = cmd_v_r;
  assign bus.resp_ready_o = resp_ready;
  assign bus.resp_o       = resp_r;
  assign bus.resp_v_o     = resp_v_r;
  assign bus.err_o        = err_r;
endmodule

// File: tb/tb_bp_mem_chan_mux.sv
// Randomised and directed bench for the memory channel mux with a
// queue-based reference model and decoupled scoreboard monitor.
module tb_bp_mem_chan_mux;
  localparam int N = 2;
  localparam int W = 128;
  localparam int E = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bp_mem_chan_mux_if #(.num_chan_p(N), .width_p(W)) bus ();

  bp_mem_chan_mux #(
    .num_chan_p(N), .width_p(W), .els_p(E)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  bit m_cmd_v;
  int m_cmd_ch;
  int m_last;
  int q_iss[$];
  bit m_held;
  int m_held_ch;
  bit m_err;
  bit m_racc;

  logic [W-1:0] exp_cmd[$];
  logic [W-1:0] exp_rd[$];
  logic [N-1:0] exp_roh[$];

  logic [N-1:0] e_ready;
  logic         e_rready;
  bit           mon_en = 0;
  bit           auto_y = 1;
  bit           auto_ry = 1;
  int           dut_acc = 0;
  logic [N-1:0] grant_log[$];
  logic [N-1:0] rv_log[$];

  task automatic chk(string name, logic [W-1:0] act,
                     logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got output with nothing expected", name);
  endtask

  function automatic logic [N-1:0] oh(int c);
    logic [N-1:0] one;
    one = 1;
    return one << c;
  endfunction

  function automatic logic [W-1:0] rw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [N*W-1:0] rcmds();
    logic [N*W-1:0] t;
    t = '0;
    for (int c = 0; c < N; c++)
      t = (t << W) | (N*W)'(rw());
    return t;
  endfunction

  function automatic int m_cnt();
    return q_iss.size() + int'(m_cmd_v) + int'(m_held);
  endfunction

  function automatic int m_winner();
    logic [N-1:0] sh;
    for (int k = 1; k <= N; k++) begin
      sh = bus.cmd_v_i >> ((m_last + k) % N);
      if (sh[0]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_rv();
    return m_held ? oh(m_held_ch) : '0;
  endfunction

  task automatic model_reset();
    m_cmd_v = 0;
    m_held  = 0;
    m_err   = 0;
    m_last  = N - 1;
    q_iss.delete();
    exp_cmd.delete();
    exp_rd.delete();
    exp_roh.delete();
  endtask

  // One clock cycle: predict, let the monitor sample, advance the model.
  task automatic step();
    int  w;
    bit  room;
    bit  issue;
    bit  pop;
    if (auto_y) bus.cmd_yumi_i = m_cmd_v;
    if (auto_ry) bus.resp_yumi_i = m_rv();
    w = m_winner();
    room = rst_n && (!m_cmd_v || bus.cmd_yumi_i) && m_cnt() < E;
    e_ready  = (room && w >= 0) ? oh(w) : '0;
    e_rready = rst_n && !m_held && q_iss.size() > 0;
    @(negedge clk);
    @(posedge clk);
    m_racc = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      issue = m_cmd_v && bus.cmd_yumi_i;
      pop   = (bus.resp_yumi_i & m_rv()) != 0;
      if (bus.resp_v_i && q_iss.size() == 0) m_err = 1;
      if ((bus.resp_yumi_i & ~m_rv()) != 0) m_err = 1;
      if (bus.cmd_yumi_i && !m_cmd_v) m_err = 1;
      if (e_rready && bus.resp_v_i) begin
        m_held_ch = q_iss.pop_front();
        m_held = 1;
        m_racc = 1;
        exp_rd.push_back(bus.resp_i);
        exp_roh.push_back(oh(m_held_ch));
      end else if (pop) begin
        m_held = 0;
      end
      if (issue) q_iss.push_back(m_cmd_ch);
      if (e_ready != 0) begin
        m_cmd_v  = 1;
        m_cmd_ch = w;
        m_last   = w;
        exp_cmd.push_back(W'(bus.cmd_i >> (w * W)));
      end else if (issue) begin
        m_cmd_v = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset(int cycles);
    rst_n = 0;
    for (int i = 0; i < cycles; i++) step();
    rst_n = 1;
  endtask

  task automatic idle_in();
    bus.cmd_v_i     = '0;
    bus.cmd_i       = rcmds();
    bus.resp_v_i    = 1'b0;
    bus.resp_i      = rw();
    bus.cmd_yumi_i  = 1'b0;
    bus.resp_yumi_i = '0;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("cmd_ready", bus.cmd_ready_o, e_ready);
      chk("resp_ready", bus.resp_ready_o, e_rready);
      chk("err", bus.err_o, m_err);
      chk("cmd_v", bus.cmd_v_o, m_cmd_v);
      chk("resp_v", bus.resp_v_o, m_rv());
      if ((bus.cmd_ready_o & bus.cmd_v_i) != 0) begin
        dut_acc++;
        grant_log.push_back(bus.cmd_ready_o);
      end
      if (bus.cmd_yumi_i && m_cmd_v) begin
        if (exp_cmd.size() == 0) fail_now("cmd_sb");
        else chk("cmd_o", bus.cmd_o, exp_cmd.pop_front());
      end
      if ((bus.resp_yumi_i & m_rv()) != 0) begin
        rv_log.push_back(bus.resp_v_o);
        if (exp_rd.size() == 0) begin
          fail_now("resp_sb");
        end else begin
          chk("resp_o", bus.resp_o, exp_rd.pop_front());
          chk("resp_route", bus.resp_v_o, exp_roh.pop_front());
        end
      end
    end
  end

  initial begin
    int a0;
    logic [W-1:0] held;
    int tries;
    idle_in();
    model_reset();
    rst_n = 0;
    step();
    mon_en = 1;
    do_reset(1);
    chk("rst_cmd_v", bus.cmd_v_o, 0);
    chk("rst_resp_v", bus.resp_v_o, 0);
    chk("rst_err", bus.err_o, 0);

    // Alternating grants with both channels requesting.
    grant_log.delete();
    bus.cmd_v_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_i = rcmds();
      step();
    end
    chk("rr_g0", grant_log[0], 2'b01);
    chk("rr_g1", grant_log[1], 2'b10);
    chk("rr_g2", grant_log[2], 2'b01);
    chk("rr_g3", grant_log[3], 2'b10);

    // Credit limit, then one freed credit reused a cycle later.
    idle_in();
    do_reset(1);
    a0 = dut_acc;
    bus.cmd_v_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      bus.cmd_i = rcmds();
      step();
    end
    chk("credit_full", dut_acc - a0, 4);
    bus.resp_v_i = 1'b1;
    bus.resp_i = rw();
    step();
    bus.resp_v_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_i = rcmds();
      step();
    end
    chk("credit_one", dut_acc - a0, 5);

    // In-order responses routed by tag.
    idle_in();
    do_reset(1);
    rv_log.delete();
    bus.cmd_v_i = 2'b10; bus.cmd_i = rcmds(); step();
    bus.cmd_v_i = 2'b01; bus.cmd_i = rcmds(); step();
    bus.cmd_v_i = 2'b10; bus.cmd_i = rcmds(); step();
    bus.cmd_v_i = 2'b00; step(); step();
    for (int r = 0; r < 3; r++) begin
      bus.resp_v_i = 1'b1;
      bus.resp_i = rw();
      tries = 0;
      do begin
        step();
        tries++;
      end while (!m_racc && tries < 10);
      if (!m_racc) fail_now("resp_timeout");
    end
    bus.resp_v_i = 1'b0;
    step(); step();
    chk("route_n", rv_log.size(), 3);
    if (rv_log.size() == 3) begin
      chk("route0", rv_log[0], 2'b10);
      chk("route1", rv_log[1], 2'b01);
      chk("route2", rv_log[2], 2'b10);
    end

    // Downstream stall holds the command and blocks grants.
    idle_in();
    do_reset(1);
    bus.cmd_v_i = 2'b01;
    bus.cmd_i = rcmds();
    held = bus.cmd_i[W-1:0];
    step();
    a0 = dut_acc;
    auto_y = 0;
    bus.cmd_yumi_i = 1'b0;
    bus.cmd_v_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_i = rcmds();
      step();
      chk("stall_cmd_o", bus.cmd_o, held);
    end
    chk("stall_grants", dut_acc - a0, 0);
    auto_y = 1;
    bus.cmd_v_i = 2'b00;
    step(); step();

    // Reset with commands outstanding.
    bus.cmd_v_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_i = rcmds();
      step();
    end
    bus.cmd_v_i = 2'b00;
    do_reset(1);
    chk("rst2_cmd_v", bus.cmd_v_o, 0);
    chk("rst2_resp_v", bus.resp_v_o, 0);
    grant_log.delete();
    bus.cmd_v_i = 2'b11;
    bus.cmd_i = rcmds();
    step();
    chk("rst2_first", grant_log.size() > 0 ? grant_log[0] : '0,
        2'b01);
    bus.cmd_v_i = 2'b00;
    step(); step();

    // Unsolicited response sets the sticky error.
    idle_in();
    do_reset(1);
    bus.resp_v_i = 1'b1;
    step();
    chk("err_set", bus.err_o, 1);
    bus.resp_v_i = 1'b0;
    step(); step(); step();
    chk("err_sticky", bus.err_o, 1);
    chk("err_no_resp", bus.resp_v_o, 0);

    // Consuming a command that is not there is also an error.
    do_reset(1);
    auto_y = 0;
    bus.cmd_yumi_i = 1'b1;
    step();
    bus.cmd_yumi_i = 1'b0;
    auto_y = 1;
    chk("err_yumi", bus.err_o, 1);

    // Randomised traffic with random backpressure on both sides.
    idle_in();
    do_reset(1);
    auto_y = 0;
    auto_ry = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.cmd_v_i = N'($urandom);
      bus.cmd_i = rcmds();
      bus.cmd_yumi_i = m_cmd_v && ($urandom_range(0, 3) != 0);
      bus.resp_v_i = (q_iss.size() > 0) && ($urandom_range(0, 1) != 0);
      bus.resp_i = rw();
      bus.resp_yumi_i = ($urandom_range(0, 2) != 0) ? m_rv() : '0;
      step();
    end
    chk("rand_err", bus.err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_mem_chan_mux.md
BP_MEM_CHAN_MUX -- requirements
Module: bp_mem_chan_mux

Interface
REQ-001 Parameter num_chan_p, default 2, number of upstream command/response channels (>=2).
REQ-002 Parameter width_p, default 128, width of one memory message in bits.
REQ-003 Parameter els_p, default 4, max outstanding commands (>=1); sizes the tag FIFO.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n_i  in  1  synchronous, active-low reset.
REQ-006 cmd_i  in  num_chan_p*width_p  per-channel command; channel i in bits [i*width_p +: width_p].
REQ-007 cmd_v_i  in  num_chan_p  per-channel command valid.
REQ-008 cmd_ready_o  out  num_chan_p  per-channel ready; transfer on cmd_v_i[i] & cmd_ready_o[i].
REQ-009 cmd_o  out  width_p  downstream command.
REQ-010 cmd_v_o  out  1  downstream command valid.
REQ-011 cmd_yumi_i  in  1  downstream consumes cmd_o this cycle; asserted only when cmd_v_o=1.
REQ-012 resp_i  in  width_p  downstream response.
REQ-013 resp_v_i  in  1  downstream response valid.
REQ-014 resp_ready_o  out  1  response buffer can accept; transfer on resp_v_i & resp_ready_o.
REQ-015 resp_o  out  width_p  response data, shared by all channels.
REQ-016 resp_v_o  out  num_chan_p  one-hot response valid to the owning channel.
REQ-017 resp_yumi_i  in  num_chan_p  channel consumes resp_o; asserted only where resp_v_o=1.
REQ-018 err_o  out  1  sticky protocol error flag.

Function
REQ-019 Command register: one entry (data + channel id, width $clog2(num_chan_p)); empty when cmd_v_o=0.
REQ-020 Outstanding counter cnt, width $clog2(els_p+1): +1 on upstream command accept, -1 on resp_yumi_i hit; both in one cycle -> unchanged.
REQ-021 Accept allowed iff (cmd register empty or cmd_yumi_i) and cnt<els_p; freed credit from a same-cycle response pop is not reused until next cycle.
REQ-022 Round-robin arbitration: search from (last_grant+1) mod num_chan_p upward with wrap; first asserted cmd_v_i wins.
REQ-023 cmd_ready_o is one-hot on the winner when accept allowed, else all zero; combinational from cmd_v_i, state, cmd_yumi_i.
REQ-024 On accept: cmd register <= winner's cmd_i, channel id stored; last_grant <= winner; winner id pushed to tag FIFO; cmd_v_o=1 next cycle.
REQ-025 Command latency: accepted command on cmd_o exactly 1 cycle after upstream handshake; back-to-back throughput 1/cycle while cmd_yumi_i held high.
REQ-026 Tag FIFO: els_p entries, circular read/write pointers with wrap at els_p; push per REQ-024, pop on response delivery; never over/underflows by construction.
REQ-027 Responses are in command order; response i routes to the channel at tag FIFO head.
REQ-028 Response buffer: one entry; resp_ready_o=1 iff buffer empty and tag FIFO non-empty holding an issued-but-unanswered tag.
REQ-029 On response accept: resp_o <= resp_i; resp_v_o <= one-hot of head tag next cycle; held stable until matching resp_yumi_i.
REQ-030 On resp_yumi_i matching resp_v_o: buffer empties, tag FIFO pops, cnt decrements; new response accepted earliest next cycle.
REQ-031 resp_v_i=1 while no unanswered tag exists: response dropped, err_o<=1.
REQ-032 resp_yumi_i bit set where resp_v_o=0, or cmd_yumi_i while cmd_v_o=0: ignored, err_o<=1.
REQ-033 err_o clears only on reset.

Reset
REQ-034 While reset_n_i=0 at clock edge: cmd_v_o=0, resp_v_o=0, cnt=0, tag pointers=0, err_o=0, last_grant=num_chan_p-1 (channel 0 first priority).
REQ-035 During reset, cmd_ready_o=0 and resp_ready_o=0; in-flight commands/responses discarded, none emitted afterward.
REQ-036 Data registers (cmd_o, resp_o) need no reset; value is don't-care while valid=0.

Verification
REQ-037 num_chan_p=2: both cmd_v_i high from reset, cmd_yumi_i=1 -> grants 0,1,0,1 on consecutive cycles; cmd_o sequence matches.
REQ-038 els_p=4, cmd_yumi_i=1, no responses: 4 commands accepted, cmd_ready_o=0 thereafter; one response delivered+yumi -> exactly one more accepted the following cycle.
REQ-039 Commands ch1,ch0,ch1 issued; memory returns R1,R2,R3 in order -> resp_v_o = 2'b10, 2'b01, 2'b10 respectively, data matching.
REQ-040 resp_v_i=1 with cnt=0 -> resp_ready_o=0, nothing delivered, err_o=1 next cycle and stays 1.
REQ-041 cmd_yumi_i=0 holding cmd_o for 5 cycles -> cmd_o stable, cmd_ready_o all 0, no further grants.
REQ-042 reset_n_i=0 for 1 cycle with 3 outstanding -> cnt=0, all valids 0, next grant to channel 0.
